// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register between core stages, with an optional skid entry (SKID=1).
// Define PIPE_STAGE_REG_PERF_EN to add saturating stall_cnt/flush_cnt outputs.
module pipe_stage_reg #(
   parameter int unsigned CTRL_W = 9,
   parameter int unsigned DATA_W = 128,
   parameter int          SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_PERF_EN
   ,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`endif
);

   logic accept;
   logic consume;

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;

`ifdef PIPE_STAGE_REG_PERF_EN
   logic any_valid;
`endif

   generate
      if (SKID != 0) begin : g_skid
         logic              skid_valid;
         logic [CTRL_W-1:0] skid_ctrl;
         logic [DATA_W-1:0] skid_data;

         // Ready is a pure function of the skid flop, so no path from out_ready.
         assign in_ready = ~skid_valid;
`ifdef PIPE_STAGE_REG_PERF_EN
         assign any_valid = out_valid | skid_valid;
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_valid  <= 1'b0;
               out_ctrl   <= '0;
               out_data   <= '0;
               skid_valid <= 1'b0;
               skid_ctrl  <= '0;
               skid_data  <= '0;
            end else if (flush) begin
               out_valid  <= 1'b0;
               out_ctrl   <= '0;
               out_data   <= '0;
               skid_valid <= 1'b0;
               skid_ctrl  <= '0;
               skid_data  <= '0;
            end else if (out_valid & ~consume) begin
               if (accept) begin
                  skid_valid <= 1'b1;
                  skid_ctrl  <= in_ctrl;
                  skid_data  <= in_data;
               end
            end else if (skid_valid) begin
               // Main is free: skid advances first so ordering stays FIFO.
               out_valid  <= 1'b1;
               out_ctrl   <= skid_ctrl;
               out_data   <= skid_data;
               skid_valid <= accept;
               if (accept) begin
                  skid_ctrl <= in_ctrl;
                  skid_data <= in_data;
               end
            end else if (accept) begin
               out_valid <= 1'b1;
               out_ctrl  <= in_ctrl;
               out_data  <= in_data;
            end else if (consume) begin
               out_valid <= 1'b0;
               out_ctrl  <= '0;
            end
         end
      end else begin : g_single
         assign in_ready = out_ready | ~out_valid;
`ifdef PIPE_STAGE_REG_PERF_EN
         assign any_valid = out_valid;
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_valid <= 1'b0;
               out_ctrl  <= '0;
               out_data  <= '0;
            end else if (flush) begin
               out_valid <= 1'b0;
               out_ctrl  <= '0;
               out_data  <= '0;
            end else if (accept) begin
               out_valid <= 1'b1;
               out_ctrl  <= in_ctrl;
               out_data  <= in_data;
            end else if (consume) begin
               // Bubble: control cleared so the slot decodes as a NOP; data holds.
               out_valid <= 1'b0;
               out_ctrl  <= '0;
            end
         end
      end
   endgenerate

`ifdef PIPE_STAGE_REG_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid & ~out_ready & (stall_cnt != '1))
            stall_cnt <= stall_cnt + 16'd1;
         if (flush & any_valid & (flush_cnt != '1))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule
